// File: rtl/countdown_led_renderer.sv
// Countdown LED strip renderer.
// Streams one frame of NUM_LEDS GRB pixels over a valid/ready handshake per frame_start
// request. The colour pattern comes from the menu/countdown state captured when the frame
// starts. Optional flash window enabled by defining COUNTDOWN_FLASH_EN.
module countdown_led_renderer #(
  parameter int unsigned  NUM_LEDS        = 100,
  parameter int unsigned  LEDS_PER_STEP   = 4,
  parameter int unsigned  FLASH_CLK_COUNT = 5000000,
  localparam int unsigned IDX_W           = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_in_menu,
  input  logic [2:0]       countdown,
  input  logic             frame_start,
  input  logic             pixel_ready,
  output logic             pixel_valid,
  output logic [23:0]      pixel_data,
  output logic [IDX_W-1:0] pixel_index,
  output logic             busy,
  output logic             frame_done,
  output logic             flash_active
);

  // Lit-length product is widened so 7 * LEDS_PER_STEP never wraps below NUM_LEDS.
  localparam int unsigned      PW        = IDX_W + 4;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 1);
  localparam logic [PW-1:0]    STEP_LEDS = PW'(LEDS_PER_STEP);

  localparam logic [23:0] ColOff   = 24'h000000;
  localparam logic [23:0] ColDim   = 24'h101010;
  localparam logic [23:0] ColRed   = 24'h00FF00;
  localparam logic [23:0] ColYel   = 24'hFFFF00;
  localparam logic [23:0] ColGrn   = 24'hFF0000;
  localparam logic [23:0] ColFlash = 24'hFFFFFF;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             capture;
  logic             snap_menu_q;
  logic [2:0]       snap_cd_q;
  logic             snap_flash_q;
  logic             flash_now;
  logic [PW-1:0]    lit_len;
  logic             lit;
  logic [23:0]      step_col;

`ifdef COUNTDOWN_FLASH_EN
  localparam int unsigned CW = $clog2(FLASH_CLK_COUNT + 1);

  logic [2:0]    prev_cd_q;
  logic [CW-1:0] flash_cnt_q;

  // Any countdown change seen in the menu (re)opens the flash window.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cd_q   <= 3'd0;
      flash_cnt_q <= '0;
    end else begin
      prev_cd_q <= countdown;
      if (is_in_menu && (countdown != prev_cd_q)) begin
        flash_cnt_q <= CW'(FLASH_CLK_COUNT);
      end else if (flash_cnt_q != '0) begin
        flash_cnt_q <= flash_cnt_q - 1'b1;
      end
    end
  end

  assign flash_now = (flash_cnt_q != '0);
`else
  assign flash_now = 1'b0;
`endif

  assign flash_active = flash_now;

  // Frame sequencing: idle -> stream NUM_LEDS pixels -> one-cycle done pulse.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StStream;
          index_d = '0;
          capture = 1'b1;
        end
      end
      StStream: begin
        if (pixel_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        index_d = '0;
      end
      default: begin
        state_d = StIdle;
        index_d = '0;
      end
    endcase
  end

  // State, pixel index and the per-frame snapshot of the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      index_q      <= '0;
      snap_menu_q  <= 1'b0;
      snap_cd_q    <= 3'd0;
      snap_flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (capture) begin
        snap_menu_q  <= is_in_menu;
        snap_cd_q    <= countdown;
        snap_flash_q <= flash_now;
      end
    end
  end

  // Pixel colour from the snapshot; data is forced to zero outside the stream.
  always_comb begin
    lit_len = PW'(snap_cd_q) * STEP_LEDS;
    lit     = ({4'b0000, index_q} < lit_len);
    if (snap_cd_q >= 3'd5) begin
      step_col = ColRed;
    end else if (snap_cd_q >= 3'd3) begin
      step_col = ColYel;
    end else begin
      step_col = ColGrn;
    end

    pixel_data = ColOff;
    if (state_q == StStream) begin
      if (snap_flash_q) begin
        pixel_data = ColFlash;
      end else if (!snap_menu_q) begin
        pixel_data = ColOff;
      end else if (snap_cd_q == 3'd0) begin
        pixel_data = ColDim;
      end else if (lit) begin
        pixel_data = step_col;
      end
    end
  end

  assign pixel_valid = (state_q == StStream);
  assign pixel_index = index_q;
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StDone);

endmodule

// File: tb/tb_countdown_led_renderer.sv
// Self-checking bench for countdown_led_renderer: a 16-LED and a 10-LED instance,
// table-driven frames, hand-written corner sequences and randomized frames against a model.
module tb_countdown_led_renderer;

`ifdef COUNTDOWN_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        is_in_menu;
  logic [2:0]  countdown;
  logic        fs16, rdy16, fs10, rdy10;
  logic        v16, b16, fd16, fa16;
  logic        v10, b10, fd10, fa10;
  logic [23:0] d16, d10;
  logic [3:0]  i16, i10;

  int n_vec  = 0;
  int n_fail = 0;

  logic [23:0] exp16 [16];

  typedef struct {
    logic        menu;
    logic [2:0]  cd;
    int          lit;
    logic [23:0] col;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  countdown_led_renderer #(
    .NUM_LEDS(16), .LEDS_PER_STEP(2), .FLASH_CLK_COUNT(20)
  ) dut16 (
    .clk(clk), .reset(reset), .is_in_menu(is_in_menu), .countdown(countdown),
    .frame_start(fs16), .pixel_ready(rdy16), .pixel_valid(v16), .pixel_data(d16),
    .pixel_index(i16), .busy(b16), .frame_done(fd16), .flash_active(fa16)
  );

  countdown_led_renderer #(
    .NUM_LEDS(10), .LEDS_PER_STEP(2), .FLASH_CLK_COUNT(20)
  ) dut10 (
    .clk(clk), .reset(reset), .is_in_menu(is_in_menu), .countdown(countdown),
    .frame_start(fs10), .pixel_ready(rdy10), .pixel_valid(v10), .pixel_data(d10),
    .pixel_index(i10), .busy(b10), .frame_done(fd10), .flash_active(fa10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Reference colour straight from the rules: flash, off, dim, lit-step or dark.
  function automatic logic [23:0] model_pix(bit menu, int cd, bit flash, int idx, int lps);
    if (flash) return 24'hFFFFFF;
    if (!menu) return 24'h000000;
    if (cd == 0) return 24'h101010;
    if (idx >= cd * lps) return 24'h000000;
    if (cd >= 5) return 24'h00FF00;
    if (cd >= 3) return 24'hFFFF00;
    return 24'hFF0000;
  endfunction

  task automatic fill_exp(input bit menu, input int cd, input bit flash);
    for (int k = 0; k < 16; k++) exp16[k] = model_pix(menu, cd, flash, k, 2);
  endtask

  // Run one 16-LED frame against exp16, with optional stall, mid-frame request,
  // mid-frame countdown change and random churn.
  task automatic frame16(input int stall_at, input int stall_len, input int fs_at,
                         input int cd_at, input logic [2:0] cd_new, input bit rnd,
                         input bit chk_lat, input string tag);
    int idx = 0;
    int cyc;
    int stalled = 0;
    bit done = 0;
    bit xfer;
    fs16 = 1'b1;
    rdy16 = 1'b1;
    step();
    fs16 = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (idx < 16) begin
        chk($sformatf("%s valid@%0d", tag, idx), 32'(v16), 32'd1);
        chk($sformatf("%s index@%0d", tag, idx), 32'(i16), 32'(idx));
        chk($sformatf("%s data@%0d", tag, idx), 32'(d16), 32'(exp16[idx]));
        chk($sformatf("%s nodone@%0d", tag, idx), 32'(fd16), 32'd0);
        rdy16 = 1'b1;
        if (idx == stall_at && stalled < stall_len) begin
          rdy16 = 1'b0;
          stalled++;
        end
        fs16 = (idx == fs_at);
        if (idx == cd_at) countdown = cd_new;
        if (rnd) begin
          rdy16 = ($urandom_range(3) != 0);
          fs16 = ($urandom_range(7) == 0);
          countdown = 3'($urandom);
          is_in_menu = 1'($urandom);
        end
        xfer = rdy16;
        step();
        cyc++;
        if (xfer) idx++;
      end else begin
        chk($sformatf("%s end valid", tag), 32'(v16), 32'd0);
        chk($sformatf("%s end frame_done", tag), 32'(fd16), 32'd1);
        chk($sformatf("%s end busy", tag), 32'(b16), 32'd1);
        // frame_start edge to frame_done cycle: 17 edges, 18 cycles counted inclusively
        if (chk_lat) chk($sformatf("%s latency", tag), 32'(cyc), 32'd17);
        fs16 = 1'b0;
        rdy16 = 1'b1;
        step();
        chk($sformatf("%s post frame_done", tag), 32'(fd16), 32'd0);
        chk($sformatf("%s post busy", tag), 32'(b16), 32'd0);
        done = 1;
      end
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s timeout: got no frame_done, expected one within 400 cycles", tag);
    end
    fs16 = 1'b0;
    rdy16 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{menu: 1'b1, cd: 3'd1, lit: 2,  col: 24'hFF0000};
    tbl[1] = '{menu: 1'b1, cd: 3'd2, lit: 4,  col: 24'hFF0000};
    tbl[2] = '{menu: 1'b1, cd: 3'd3, lit: 6,  col: 24'hFFFF00};
    tbl[3] = '{menu: 1'b1, cd: 3'd4, lit: 8,  col: 24'hFFFF00};
    tbl[4] = '{menu: 1'b1, cd: 3'd5, lit: 10, col: 24'h00FF00};
    tbl[5] = '{menu: 1'b1, cd: 3'd6, lit: 12, col: 24'h00FF00};
    tbl[6] = '{menu: 1'b1, cd: 3'd7, lit: 14, col: 24'h00FF00};
    tbl[7] = '{menu: 1'b1, cd: 3'd0, lit: 16, col: 24'h101010};
    tbl[8] = '{menu: 1'b0, cd: 3'd5, lit: 0,  col: 24'h000000};

    reset = 1'b1;
    is_in_menu = 1'b0;
    countdown = 3'd0;
    fs16 = 1'b0;
    rdy16 = 1'b1;
    fs10 = 1'b0;
    rdy10 = 1'b1;
    idle(3);
    chk("reset valid", 32'(v16), 32'd0);
    chk("reset data", 32'(d16), 32'd0);
    chk("reset index", 32'(i16), 32'd0);
    chk("reset busy", 32'(b16), 32'd0);
    chk("reset frame_done", 32'(fd16), 32'd0);
    chk("reset flash", 32'(fa16), 32'd0);
    reset = 1'b0;
    step();

    // Table-driven full frames with pixel_ready held high.
    for (int t = 0; t < 9; t++) begin
      is_in_menu = tbl[t].menu;
      countdown = tbl[t].cd;
      idle(25);
      for (int k = 0; k < 16; k++) exp16[k] = (k < tbl[t].lit) ? tbl[t].col : 24'h000000;
      frame16(-1, 0, -1, -1, 3'd0, 1'b0, 1'b1, $sformatf("tbl%0d", t));
    end

    // Backpressure at index 4 for five cycles.
    is_in_menu = 1'b1;
    countdown = 3'd3;
    idle(25);
    fill_exp(1'b1, 3, 1'b0);
    frame16(4, 5, -1, -1, 3'd0, 1'b0, 1'b0, "stall");

    // Second request and countdown change mid-frame are both ignored.
    idle(25);
    frame16(-1, 0, 8, 8, 3'd2, 1'b0, 1'b1, "midreq");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midreq no restart %0d", k), 32'(b16), 32'd0);
      step();
    end

    // 10-LED strip, countdown 7: 14 >= 10 lights everything.
    is_in_menu = 1'b1;
    countdown = 3'd7;
    idle(25);
    fs10 = 1'b1;
    step();
    fs10 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("n10 valid@%0d", k), 32'(v10), 32'd1);
      chk($sformatf("n10 index@%0d", k), 32'(i10), 32'(k));
      chk($sformatf("n10 data@%0d", k), 32'(d10), 32'h00FF00);
      step();
    end
    chk("n10 valid end", 32'(v10), 32'd0);
    chk("n10 frame_done", 32'(fd10), 32'd1);
    step();
    chk("n10 frame_done clear", 32'(fd10), 32'd0);

    // Reset at index 5 aborts without a done pulse.
    countdown = 3'd3;
    idle(25);
    fs16 = 1'b1;
    step();
    fs16 = 1'b0;
    idle(5);
    chk("abort index before reset", 32'(i16), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort valid", 32'(v16), 32'd0);
    chk("abort busy", 32'(b16), 32'd0);
    chk("abort frame_done", 32'(fd16), 32'd0);
    chk("abort index", 32'(i16), 32'd0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("abort no done %0d", k), 32'(fd16), 32'd0);
      step();
    end

    // Reset wins over a simultaneous frame_start.
    reset = 1'b1;
    fs16 = 1'b1;
    step();
    reset = 1'b0;
    fs16 = 1'b0;
    chk("reset prio busy", 32'(b16), 32'd0);
    chk("reset prio valid", 32'(v16), 32'd0);

    // Flash window: countdown 4 -> 3 in the menu.
    is_in_menu = 1'b1;
    countdown = 3'd4;
    idle(25);
    chk("flash idle", 32'(fa16), 32'd0);
    countdown = 3'd3;
    step();
    chk("flash open", 32'(fa16), 32'(FLASH_ON));
    idle(4);
    fill_exp(1'b1, 3, FLASH_ON);
    frame16(-1, 0, -1, -1, 3'd0, 1'b0, 1'b1, "flash");
    idle(10);
    chk("flash closed", 32'(fa16), 32'd0);
    fill_exp(1'b1, 3, 1'b0);
    frame16(-1, 0, -1, -1, 3'd0, 1'b0, 1'b1, "postflash");

    // Randomized frames against the model; inputs churn while streaming.
    for (int r = 0; r < 8; r++) begin
      bit m;
      int c;
      m = 1'($urandom);
      c = int'($urandom_range(7));
      is_in_menu = m;
      countdown = 3'(c);
      idle(25);
      fill_exp(m, c, 1'b0);
      frame16(-1, 0, -1, -1, 3'd0, 1'b1, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
